// File: rtl/hadamard_pkg.sv
// Shared types for the Hadamard scheduler: element width, element and quad types.
package hadamard_pkg;

  localparam int unsigned W = 16;

  typedef logic signed [W-1:0] elem_t;

  // Operand set on the way in, transform result on the way out (a0..a3 = g0..g3).
  typedef struct packed {
    elem_t a0;
    elem_t a1;
    elem_t a2;
    elem_t a3;
  } quad_t;

endpackage

// File: rtl/hadamard_sched_if.sv
// Handshake bundle of hadamard_sched: two operand requesters, one result channel, status.
//   master: requester/consumer side (drives in*_valid, in*_a*, out_ready)
//   slave : scheduler side (drives in*_ready, out_*, busy, xfer_count)
interface hadamard_sched_if;
  import hadamard_pkg::*;

  logic        in0_valid;
  logic        in0_ready;
  elem_t       in0_a0, in0_a1, in0_a2, in0_a3;

  logic        in1_valid;
  logic        in1_ready;
  elem_t       in1_a0, in1_a1, in1_a2, in1_a3;

  logic        out_valid;
  logic        out_ready;
  elem_t       out_g0, out_g1, out_g2, out_g3;
  logic        out_src;

  logic        busy;
  logic [31:0] xfer_count;

  modport master (
    output in0_valid, in0_a0, in0_a1, in0_a2, in0_a3,
    output in1_valid, in1_a0, in1_a1, in1_a2, in1_a3,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_g0, out_g1, out_g2, out_g3, out_src,
    input  busy, xfer_count
  );

  modport slave (
    input  in0_valid, in0_a0, in0_a1, in0_a2, in0_a3,
    input  in1_valid, in1_a0, in1_a1, in1_a2, in1_a3,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_g0, out_g1, out_g2, out_g3, out_src,
    output busy, xfer_count
  );

endinterface

// File: rtl/hadamard_sched_arb.sv
// Two-input round-robin arbiter.
//   req     : request vector
//   accept  : the granted request was taken this cycle; advances the pointer
//   grant_c : one-hot grant, combinational from req and the pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_c
);

  // Index of the most recently accepted requester; reset to 1 so requester 0 wins first.
  logic last_q;

  // Grant logic: lone requester wins, otherwise the one that did not go last.
  always_comb begin
    grant_c = 2'b00;
    if (req[0] && (!req[1] || last_q)) begin
      grant_c[0] = 1'b1;
    end else if (req[1]) begin
      grant_c[1] = 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant_c[1];
    end
  end

endmodule

// File: rtl/hadamard_sched_xform.sv
// 4-point Hadamard transform, purely combinational, wrapping modulo 2^W.
//   a   : operand set
//   g_c : transform result
module hadamard4
  import hadamard_pkg::*;
(
  input  quad_t a,
  output quad_t g_c
);

  always_comb begin
    g_c    = '0;
    g_c.a0 = a.a0 + a.a1 + a.a2 + a.a3;
    g_c.a1 = a.a0 - a.a1 + a.a2 - a.a3;
    g_c.a2 = a.a0 + a.a1 - a.a2 - a.a3;
    g_c.a3 = a.a0 - a.a1 - a.a2 + a.a3;
  end

endmodule

// File: rtl/hadamard_sched.sv
// Two-requester scheduler sharing one Hadamard datapath: round-robin arbitration
// into an operand register (S1), transform into an output register (S2).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester/result/status bundle (slave side)
//     in*_ready is combinational; all other outputs are registered.
module hadamard_sched #(
  parameter int unsigned W = hadamard_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  hadamard_sched_if.slave  bus
);
  import hadamard_pkg::*;

  // The element type lives in the package; the parameter only documents it.
  if (W != hadamard_pkg::W) begin : g_width_check
    $error("hadamard_sched: W must equal hadamard_pkg::W");
  end

  logic [1:0]  req;
  logic [1:0]  grant_c;
  logic        s1_load, s2_load, accept;
  logic        in0_ready, in1_ready;
  logic        s1_valid_d, out_valid_d;
  quad_t       op_c, g_c;

  logic        s1_valid_q, s1_src_q;
  quad_t       s1_q;
  logic        out_valid_q, out_src_q;
  quad_t       out_q;
  logic        busy_q;
  logic [31:0] xfer_q;

  assign req = {bus.in1_valid, bus.in0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .accept  (accept),
    .grant_c (grant_c)
  );

  hadamard4 u_xform (
    .a   (s1_q),
    .g_c (g_c)
  );

  // Advance rules, handshake and operand select.
  always_comb begin
    s2_load     = s1_valid_q && (!out_valid_q || bus.out_ready);
    s1_load     = !s1_valid_q || s2_load;
    // Gate with rst_n so no requester sees ready while reset is held.
    in0_ready   = rst_n && s1_load && grant_c[0];
    in1_ready   = rst_n && s1_load && grant_c[1];
    accept      = in0_ready || in1_ready;
    s1_valid_d  = s1_load ? accept : s1_valid_q;
    out_valid_d = s2_load || (out_valid_q && !bus.out_ready);
    if (grant_c[1]) begin
      op_c = '{a0: bus.in1_a0, a1: bus.in1_a1, a2: bus.in1_a2, a3: bus.in1_a3};
    end else begin
      op_c = '{a0: bus.in0_a0, a1: bus.in0_a1, a2: bus.in0_a2, a3: bus.in0_a3};
    end
  end

  // Pipeline registers, status and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_src_q    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      xfer_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      busy_q      <= s1_valid_d || out_valid_d;
      if (accept) begin
        s1_q     <= op_c;
        s1_src_q <= grant_c[1];
      end
      if (s2_load) begin
        out_q     <= g_c;
        out_src_q <= s1_src_q;
      end
      if (out_valid_q && bus.out_ready) begin
        xfer_q <= xfer_q + 32'd1;
      end
    end
  end

  assign bus.in0_ready  = in0_ready;
  assign bus.in1_ready  = in1_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_g0     = out_q.a0;
  assign bus.out_g1     = out_q.a1;
  assign bus.out_g2     = out_q.a2;
  assign bus.out_g3     = out_q.a3;
  assign bus.busy       = busy_q;
  assign bus.xfer_count = xfer_q;

endmodule

// File: doc/hadamard_sched.md
# hadamard_sched

Two-requester scheduler that shares one combinational 4-point Hadamard transform datapath between two independent valid/ready sources. It arbitrates round-robin, registers the granted operand set, and presents the transformed result with a source tag on a single valid/ready output channel. It sits between the quaternion operand producers and the downstream accumulate/writeback logic of the accelerator.

## Interface
Parameters:
- `W`, 16: element width, signed two's complement.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in0_valid`, input, 1: requester 0 has an operand set.
- `in0_ready`, output, 1: requester 0 operand set accepted this cycle when high together with `in0_valid`.
- `in0_a0` … `in0_a3`, input, W each: requester 0 operands.
- `in1_valid`, `in1_ready`, `in1_a0` … `in1_a3`: same as above, for requester 1.
- `out_valid`, output, 1: result held on `out_g*`.
- `out_ready`, input, 1: downstream consumes the result.
- `out_g0` … `out_g3`, output, W each: transform result.
- `out_src`, output, 1: index of the requester that produced the result.
- `busy`, output, 1: high when any pipeline stage holds data.
- `xfer_count`, output, 32: number of completed output handshakes.

## Operation
- **Transform.** All arithmetic is modulo 2^W. Overflow wraps and is never flagged.
  - g0 = a0+a1+a2+a3
  - g1 = a0−a1+a2−a3
  - g2 = a0+a1−a2−a3
  - g3 = a0−a1−a2+a3
- **Pipeline.**
  - S1 is the operand register: a0..a3, src, `s1_valid`.
  - S2 is the output register: g0..g3, src, `out_valid`. The transform is computed combinationally from S1 into S2.
- **Advance rules.**
  - `s2_load = s1_valid && (!out_valid || out_ready)`.
  - `s1_load = !s1_valid || s2_load`.
  - A full pipeline with `out_ready` high sustains 1 result per cycle.
- **Arbitration.** Round-robin using a 1-bit `last` pointer.
  - With one requester valid, that requester is granted.
  - With both valid, the requester ≠ `last` is granted.
  - `inX_ready = grantX && s1_load`. This is combinational and carries no dependency on the other requester's ready.
  - `last` updates only on an accepted handshake.
- **Hold.** While `out_valid && !out_ready`, `out_g*` and `out_src` are stable. S1 holds. Both `inX_ready` are low once S1 is full.
- **Counters and status.**
  - `xfer_count` increments on each `out_valid && out_ready` and wraps at 2^32.
  - `busy = s1_valid || out_valid`.
- **Source rule.** A requester may not deassert `valid` or change its operands until accepted. The block does not check this.

## Timing
- **Reset values** (on `rst_n` low, asynchronous):
  - `s1_valid=0`, `out_valid=0`, `out_g*=0`, `out_src=0`.
  - `last=1`, so requester 0 wins the first contention.
  - `xfer_count=0`.
  - `busy=0`. `in*_ready=0` while in reset.
- **Latency.** Accept at edge N means `out_valid` is high after edge N+1, i.e. 2 cycles from accept to result, provided the output is not stalled.
- **Mid-operation reset.** In-flight data is discarded. No output handshake completes on the reset edge.
- **Simultaneous output consume and S1 refill.** Both happen in the same cycle, with no bubble.
- **Outputs.** All outputs except `in*_ready` are registered.

## Structure
- Shared package `hadamard_pkg`:
  - `W` default.
  - `typedef logic signed [W-1:0] elem_t`.
  - `typedef struct { elem_t a0, a1, a2, a3; }` operand/result type `quad_t`.
- One natural sub-module, `rr_arb2`: 2-input round-robin arbiter with the `last` pointer and grant logic, pointer updated on `accept`.
- The transform itself uses the existing 4-point Hadamard datapath, instantiated once between S1 and S2.
- Expected total RTL is about 150–250 lines.

## Test plan
- **Single transform.** After reset, req0 sends (1,2,3,4) with `out_ready=1` → `out_valid` 2 cycles after accept, g=(10,−2,−4,0), `out_src=0`, `xfer_count=1`.
- **Wrap.** req1 sends (32767,1,0,0) → g=(−32768,32766,−32768,32766), `out_src=1`.
- **Contention.** Both requesters hold valid for 6 cycles with `out_ready=1` → grants alternate 0,1,0,1,0,1. Output stream shows 1 result per cycle after the 2-cycle fill.
- **Backpressure.** Hold `out_ready=0` for 5 cycles with both valid → exactly 2 sets accepted, `out_g*` stable, both readies low. On release, results drain in accept order with no loss or duplication.
- **Reset mid-operation.** Assert `rst_n=0` with S1 and S2 full → all outputs return to their reset values immediately. After release, req0 wins the first contention.
- **Counter.** 1000 random transforms against a reference model → every result matches, and `xfer_count=1000`.
